output_write_buffer: RTL and testbench
======================================

# output_write_buffer

Small synchronous FIFO plus drain engine sitting directly downstream of the write-buffer controller. It accepts result words when the controller pulses `buffer_write_en` and reports space back to it on `buffer_ready`. It drains queued words to the output memory over a req/ack handshake with an auto-incrementing address. A full buffer is what drives the controller into its stall path.

## Interface
- `DATA_WIDTH`, 16: width of one result word.
- `DEPTH`, 4: FIFO entries; power of two, ≥ 2.
- `ADDR_WIDTH`, 8: output memory address width.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `buffer_write_en`  in  1  push request from write-buffer controller.
- `wr_data`  in  DATA_WIDTH  word to push; sampled with `buffer_write_en`.
- `buffer_ready`  out  1  space available: `count < DEPTH`.
- `mem_req`  out  1  drain request to output memory.
- `mem_addr`  out  ADDR_WIDTH  target address; valid while `mem_req`.
- `mem_data`  out  DATA_WIDTH  FIFO head word; valid while `mem_req`.
- `mem_ack`  in  1  memory accepted the current word.
- `addr_clear`  in  1  reset drain address to 0 (start of a new output tile).
- `count`  out  $clog2(DEPTH)+1  occupied entries.
- `empty`  out  1  `count == 0`.
- `overflow`  out  1  sticky: a push was attempted while full.

## Operation
- Push is accepted when `buffer_write_en && buffer_ready`. `wr_data` goes to the tail, the write pointer increments mod DEPTH, and `count` increments.
- Push while full: the word is dropped, `overflow` is set to 1, and it holds until `rst`. Pointers and `count` do not change.
- `buffer_ready` is derived from the registered `count` of the current cycle. A pop in the same cycle does not free space for a same-cycle push; full stays full for that push.
- Drain FSM has two states:
  - `D_IDLE`: `mem_req=0`. If `!empty`, go to `D_REQ`.
  - `D_REQ`: `mem_req=1`, `mem_data`=head, `mem_addr`=address counter.
    - On `mem_ack`: pop (read pointer +1 mod DEPTH, `count`−1) and address +1.
    - After that pop, stay in `D_REQ` if `count > 1`; otherwise go to `D_IDLE`.
    - Without `mem_ack`, hold all outputs stable.
- `mem_ack` in `D_IDLE` is ignored.
- Simultaneous accepted push and ack-pop: `count` is unchanged and both pointers advance.
- Address counter increments mod 2^ADDR_WIDTH (0xFF → 0x00 at default width).
- `addr_clear` sets the address to 0 on the next edge. If asserted in the same cycle as an ack, clear wins (next address is 0, not +1). The FIFO is unaffected.
- `rst` (synchronous): pointers, `count`, address and `overflow` go to 0, and the FSM goes to `D_IDLE`. Queued data is discarded, including a word mid-handshake; `mem_req` is 0 from the cycle after the reset edge.

## Timing
- Reset values: `buffer_ready=1`, `mem_req=0`, `mem_addr=0`, `mem_data` = stale RAM content (don't care), `count=0`, `empty=1`, `overflow=0`.
- Latency into empty buffer:
  - Push at edge k makes `count=1`.
  - FSM enters `D_REQ` at edge k+1.
  - `mem_req` is high in the cycle after edge k+1.
- Back-to-back drain: with `mem_ack` held high and data queued, one word retires per cycle and `mem_req` stays high.
- `mem_req` never drops without an ack except on `rst`.
- The memory may hold `mem_ack` low indefinitely. The buffer then fills, `buffer_ready` falls, and the upstream controller stalls.
- No combinational path from `mem_ack` or `buffer_write_en` to `buffer_ready`, `mem_req` or `mem_addr`.

## Structure
- Shared package `output_buffer_pkg` holds:
  - the drain state encoding `D_IDLE=1'b0`, `D_REQ=1'b1`;
  - default width constants shared with the write-buffer controller and memory model.
- Sub-module `sync_fifo` (storage, pointers, `count`, `empty`/`full`, push/pop) is instantiated once. Drain FSM, address counter and overflow flag live in the top.

## Test plan
- Reset, then push 0x1111 with `mem_ack` tied high → `mem_req` rises two cycles after the push cycle with `mem_addr=0`, `mem_data=0x1111`; `empty=1` after the ack.
- Push 4 words with `mem_ack=0` → `count=4`, `buffer_ready=0`. A fifth push leaves `count=4` and sets `overflow=1`; drained order is the first four words at addresses 0..3.
- Full buffer, push and ack in the same cycle → push rejected, `count=3` afterwards, `overflow=1`.
- Preload address to 0xFE, drain 3 words → addresses 0xFE, 0xFF, 0x00.
- `addr_clear` asserted in the same cycle as an ack at address 5 → next `mem_addr=0`.
- `rst` asserted while `mem_req=1` with `count=3` → next cycle `mem_req=0`, `count=0`, `buffer_ready=1`, `overflow=0`, and no further requests.

Source files
------------

// File: rtl/output_buffer_pkg.sv
// Shared definitions for the output write buffer, its upstream controller and
// the output memory model.
package output_buffer_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int DEFAULT_DEPTH      = 4;
  localparam int DEFAULT_ADDR_WIDTH = 8;

  typedef enum logic {
    D_IDLE = 1'b0,
    D_REQ  = 1'b1
  } drain_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Power-of-two synchronous FIFO with registered occupancy count.
// A push is refused when the current registered count is full, even if a pop happens in the same cycle.
module sync_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  output logic [DATA_WIDTH-1:0]      rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_COUNT);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/output_write_buffer.sv
// Output write buffer: FIFO plus a req/ack drain engine with an auto-incrementing
// output memory address and a sticky overflow flag.
module output_write_buffer
  import output_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     buffer_write_en,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  output logic                     buffer_ready,
  output logic                     mem_req,
  output logic [ADDR_WIDTH-1:0]    mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_data,
  input  logic                     mem_ack,
  input  logic                     addr_clear,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     overflow
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] ONE = CW'(1);

  drain_state_t state;
  drain_state_t state_next;
  logic         full;
  logic         pop;

  assign pop          = (state == D_REQ) && mem_ack;
  assign buffer_ready = !full;

  sync_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (buffer_write_en),
    .pop    (pop),
    .wr_data(wr_data),
    .rd_data(mem_data),
    .count  (count),
    .empty  (empty),
    .full   (full)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= D_IDLE;
    else     state <= state_next;
  end

  // The stay/leave decision uses the count before the pop, so a lone word always returns to idle.
  always_comb begin
    state_next = state;
    case (state)
      D_IDLE:  if (!empty) state_next = D_REQ;
      D_REQ:   if (mem_ack) state_next = (count > ONE) ? D_REQ : D_IDLE;
      default: state_next = D_IDLE;
    endcase
  end

  always_comb begin
    mem_req = 1'b0;
    if (state == D_REQ) mem_req = 1'b1;
  end

  // A clear takes priority over an increment in the same cycle.
  always_ff @(posedge clk) begin
    if (rst)             mem_addr <= '0;
    else if (addr_clear) mem_addr <= '0;
    else if (pop)        mem_addr <= mem_addr + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)                          overflow <= 1'b0;
    else if (buffer_write_en && full) overflow <= 1'b1;
  end

endmodule

// File: tb/tb_output_write_buffer.sv
// Scoreboard bench for output_write_buffer: accepted pushes are queued and
// compared against each completed mem_req/mem_ack handshake.
module tb_output_write_buffer;

  localparam int DW = 16;
  localparam int DP = 4;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          buffer_write_en;
  logic [DW-1:0] wr_data;
  logic          buffer_ready;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          mem_ack;
  logic          addr_clear;
  logic [2:0]    count;
  logic          empty;
  logic          overflow;

  int            errors = 0;
  int            checks = 0;
  logic [DW-1:0] sb [$];
  logic [AW-1:0] addr_model = '0;

  output_write_buffer #(.DATA_WIDTH(DW), .DEPTH(DP), .ADDR_WIDTH(AW)) dut (
    .clk            (clk),
    .rst            (rst),
    .buffer_write_en(buffer_write_en),
    .wr_data        (wr_data),
    .buffer_ready   (buffer_ready),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_data       (mem_data),
    .mem_ack        (mem_ack),
    .addr_clear     (addr_clear),
    .count          (count),
    .empty          (empty),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Inputs are stable at the falling edge; a handshake seen there retires on the next rising edge.
  always @(negedge clk) begin
    if (rst) begin
      addr_model <= '0;
    end else if (mem_req && mem_ack) begin
      if (sb.size() == 0) begin
        checkOutput("sb_underflow", 32'd1, 32'd0);
      end else begin
        checkOutput("drain_data", 32'(mem_data), 32'(sb.pop_front()));
        checkOutput("drain_addr", 32'(mem_addr), 32'(addr_model));
      end
      addr_model <= addr_clear ? '0 : addr_model + 1'b1;
    end else if (addr_clear) begin
      addr_model <= '0;
    end
  end

  task automatic applyStimulus(input logic [DW-1:0] word, input bit accept);
    buffer_write_en = 1'b1;
    wr_data         = word;
    if (accept) sb.push_back(word);
    tick();
    buffer_write_en = 1'b0;
  endtask

  task automatic resetDut();
    rst = 1'b1;
    sb.delete();
    tick();
    rst = 1'b0;
  endtask

  task automatic clearAddr();
    addr_clear = 1'b1;
    tick();
    addr_clear = 1'b0;
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 50 && sb.size() != 0; i++) tick();
    checkOutput("drain_timeout", 32'(sb.size()), 32'd0);
    tick();
  endtask

  task automatic pushAndRetire(input logic [DW-1:0] word);
    applyStimulus(word, 1'b1);
    tick();
    tick();
  endtask

  initial begin
    rst = 1'b1; buffer_write_en = 1'b0; wr_data = '0; mem_ack = 1'b0; addr_clear = 1'b0;
    tick();
    tick();
    checkOutput("rst_ready", 32'(buffer_ready), 32'd1);
    checkOutput("rst_req", 32'(mem_req), 32'd0);
    checkOutput("rst_addr", 32'(mem_addr), 32'd0);
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_empty", 32'(empty), 32'd1);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    rst = 1'b0;

    // Single word, ack tied high
    mem_ack = 1'b1;
    applyStimulus(16'h1111, 1'b1);
    checkOutput("lat_count", 32'(count), 32'd1);
    checkOutput("lat_req_early", 32'(mem_req), 32'd0);
    tick();
    checkOutput("lat_req", 32'(mem_req), 32'd1);
    checkOutput("lat_addr", 32'(mem_addr), 32'd0);
    checkOutput("lat_data", 32'(mem_data), 32'h1111);
    tick();
    checkOutput("lat_empty", 32'(empty), 32'd1);
    checkOutput("lat_req_drop", 32'(mem_req), 32'd0);

    // Fill with memory stalled, then overflow
    mem_ack = 1'b0;
    clearAddr();
    for (int i = 0; i < 4; i++) applyStimulus(16'hA000 + 16'(i), 1'b1);
    checkOutput("full_count", 32'(count), 32'd4);
    checkOutput("full_ready", 32'(buffer_ready), 32'd0);
    checkOutput("full_no_ovf", 32'(overflow), 32'd0);
    applyStimulus(16'hDEAD, 1'b0);
    checkOutput("ovf_count", 32'(count), 32'd4);
    checkOutput("ovf_flag", 32'(overflow), 32'd1);
    checkOutput("ovf_head_addr", 32'(mem_addr), 32'd0);
    mem_ack = 1'b1;
    waitDrain();
    checkOutput("drain4_addr", 32'(mem_addr), 32'd4);
    checkOutput("drain4_empty", 32'(empty), 32'd1);
    mem_ack = 1'b0;

    // Full buffer: push and ack in the same cycle
    resetDut();
    for (int i = 0; i < 4; i++) applyStimulus(16'hB000 + 16'(i), 1'b1);
    buffer_write_en = 1'b1;
    wr_data = 16'hBEEF;
    mem_ack = 1'b1;
    tick();
    buffer_write_en = 1'b0;
    mem_ack = 1'b0;
    checkOutput("fullpop_count", 32'(count), 32'd3);
    checkOutput("fullpop_ovf", 32'(overflow), 32'd1);
    checkOutput("fullpop_ready", 32'(buffer_ready), 32'd1);
    mem_ack = 1'b1;
    waitDrain();

    // Address wrap: advance to 0xFE, then drain three words
    clearAddr();
    for (int i = 0; i < 254; i++) pushAndRetire(16'(i));
    checkOutput("wrap_pre_addr", 32'(mem_addr), 32'hFE);
    mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(16'hC000 + 16'(i), 1'b1);
    tick();
    checkOutput("wrap_req_addr", 32'(mem_addr), 32'hFE);
    mem_ack = 1'b1;
    waitDrain();
    checkOutput("wrap_post_addr", 32'(mem_addr), 32'd1);

    // Clear coinciding with an ack at address 5
    clearAddr();
    for (int i = 0; i < 5; i++) pushAndRetire(16'h0500 + 16'(i));
    mem_ack = 1'b0;
    applyStimulus(16'hD005, 1'b1);
    applyStimulus(16'hD006, 1'b1);
    checkOutput("clr_pre_addr", 32'(mem_addr), 32'd5);
    mem_ack = 1'b1;
    addr_clear = 1'b1;
    tick();
    mem_ack = 1'b0;
    addr_clear = 1'b0;
    checkOutput("clr_addr", 32'(mem_addr), 32'd0);
    checkOutput("clr_req", 32'(mem_req), 32'd1);
    checkOutput("clr_data", 32'(mem_data), 32'hD006);
    mem_ack = 1'b1;
    waitDrain();

    // Reset mid-handshake with three words queued
    mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(16'hE000 + 16'(i), 1'b1);
    applyStimulus(16'hE003, 1'b1);
    applyStimulus(16'hE004, 1'b0);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    checkOutput("mid_req", 32'(mem_req), 32'd1);
    checkOutput("mid_count", 32'(count), 32'd3);
    checkOutput("mid_ovf", 32'(overflow), 32'd1);
    resetDut();
    checkOutput("mrst_req", 32'(mem_req), 32'd0);
    checkOutput("mrst_count", 32'(count), 32'd0);
    checkOutput("mrst_ready", 32'(buffer_ready), 32'd1);
    checkOutput("mrst_ovf", 32'(overflow), 32'd0);
    checkOutput("mrst_addr", 32'(mem_addr), 32'd0);
    mem_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("mrst_no_req", 32'(mem_req), 32'd0);
    end
    mem_ack = 1'b0;

    checkOutput("sb_left", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
